// File: rtl/apxoa_pkg.sv
// Shared constants and helper functions for the approximate-compressor final-add stage.
package apxoa_pkg;

  localparam int unsigned APXOA_W_DEF     = 16;
  localparam int unsigned APXOA_CNT_W_DEF = 16;
  // Widest error vector the popcount helper handles (callers zero-extend into it).
  localparam int unsigned POP_MAX_W       = 64;

  function automatic logic [31:0] popcount(input logic [POP_MAX_W-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < int'(POP_MAX_W); i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

  // Adds and clamps to the largest value representable in w bits (w <= 32).
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] s;
    logic [32:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (s > lim) ? lim[31:0] : s[31:0];
  endfunction

endpackage

// File: rtl/apxoa_final_add_csa3.sv
// N-bit 3:2 carry-save row: a + b + c == s + (c_o << 1). Pure combinational.
module apxoa_csa3 #(
  parameter int unsigned N = 18
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [N-1:0] c_i,
  output logic [N-1:0] s_o,
  output logic [N-1:0] c_o
);

  genvar gi;
  generate
    for (gi = 0; gi < int'(N); gi++) begin : g_fa
      assign s_o[gi] = a_i[gi] ^ b_i[gi] ^ c_i[gi];
      assign c_o[gi] = (a_i[gi] & b_i[gi]) | (a_i[gi] & c_i[gi]) | (b_i[gi] & c_i[gi]);
    end
  endgenerate

endmodule

// File: rtl/apxoa_final_add.sv
// Two-stage final adder (CSA then CPA) for the compressor row, with valid/ready
// handshake and saturating error statistics counters.
module apxoa_final_add
  import apxoa_pkg::*;
#(
  parameter int unsigned W     = APXOA_W_DEF,
  parameter int unsigned CNT_W = APXOA_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     sum_vec,
  input  logic [W-1:0]     carry_vec,
  input  logic [W-1:0]     err_vec,
  input  logic             comp_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W+2:0]     result,
  output logic             out_err,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_col_cnt,
  output logic [CNT_W-1:0] err_beat_cnt
);

  localparam int unsigned SW = W + 2;

  logic          adv1, adv2, accept;
  logic          v1_q, v1_d, v2_q, v2_d;
  logic [SW-1:0] op_a, op_b, op_c, csa_s, csa_c;
  logic [SW-1:0] s1_q, s1_d, c1_q, c1_d;
  logic          err1_q, err1_d;
  logic [W+2:0]  res_q, res_d;
  logic          err2_q, err2_d;

  // Stage 2 drains or is empty -> stage 1 may move; in_ready follows out_ready combinationally.
  assign adv2     = ~v2_q | out_ready;
  assign adv1     = ~v1_q | adv2;
  assign in_ready = adv1;
  assign accept   = in_valid & adv1;

  // Carry and compensation columns both carry weight 2^(i+1).
  assign op_a = {2'b00, sum_vec};
  assign op_b = {1'b0, carry_vec, 1'b0};
  assign op_c = comp_en ? {1'b0, err_vec, 1'b0} : '0;

  apxoa_csa3 #(.N(SW)) u_csa (
    .a_i (op_a),
    .b_i (op_b),
    .c_i (op_c),
    .s_o (csa_s),
    .c_o (csa_c)
  );

  always_comb begin
    v1_d   = v1_q;
    s1_d   = s1_q;
    c1_d   = c1_q;
    err1_d = err1_q;
    v2_d   = v2_q;
    res_d  = res_q;
    err2_d = err2_q;
    if (adv1) begin
      v1_d = in_valid;
      if (in_valid) begin
        s1_d   = csa_s;
        c1_d   = csa_c;
        err1_d = |err_vec;
      end
    end
    // Result only changes on a real transfer, so it holds across idle cycles.
    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        res_d  = {1'b0, s1_q} + {c1_q, 1'b0};
        err2_d = err1_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      s1_q   <= '0;
      c1_q   <= '0;
      err1_q <= 1'b0;
      v2_q   <= 1'b0;
      res_q  <= '0;
      err2_q <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      s1_q   <= s1_d;
      c1_q   <= c1_d;
      err1_q <= err1_d;
      v2_q   <= v2_d;
      res_q  <= res_d;
      err2_q <= err2_d;
    end
  end

  assign out_valid = v2_q;
  assign result    = res_q;
  assign out_err   = err2_q;

  logic [CNT_W-1:0] samp_q, samp_d, col_q, col_d, beat_q, beat_d;
  logic [31:0]      samp_sum, col_sum, beat_sum, err_pop;

  assign err_pop  = popcount({{(POP_MAX_W - W){1'b0}}, err_vec});
  assign samp_sum = sat_add(32'(samp_q), 32'd1, CNT_W);
  assign col_sum  = sat_add(32'(col_q), err_pop, CNT_W);
  assign beat_sum = sat_add(32'(beat_q), {31'd0, |err_vec}, CNT_W);

  // Clear has priority over a beat accepted in the same cycle.
  always_comb begin
    samp_d = samp_q;
    col_d  = col_q;
    beat_d = beat_q;
    if (clr_stats) begin
      samp_d = '0;
      col_d  = '0;
      beat_d = '0;
    end else if (accept) begin
      samp_d = samp_sum[CNT_W-1:0];
      col_d  = col_sum[CNT_W-1:0];
      beat_d = beat_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      samp_q <= '0;
      col_q  <= '0;
      beat_q <= '0;
    end else begin
      samp_q <= samp_d;
      col_q  <= col_d;
      beat_q <= beat_d;
    end
  end

  assign sample_cnt   = samp_q;
  assign err_col_cnt  = col_q;
  assign err_beat_cnt = beat_q;

endmodule

// File: tb/tb_apxoa_final_add.sv
// Randomised self-checking bench for apxoa_final_add (W=8, CNT_W=4) against an
// arithmetic scoreboard and clamped-counter model.
module tb_apxoa_final_add;

  localparam int W     = 8;
  localparam int CNT_W = 4;
  localparam int RW    = W + 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n, in_valid, in_ready, comp_en, out_valid, out_ready, out_err, clr_stats;
  logic [W-1:0]     sum_vec, carry_vec, err_vec;
  logic [RW-1:0]    result;
  logic [CNT_W-1:0] sample_cnt, err_col_cnt, err_beat_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  int q_res[$];
  bit q_err[$];
  int m_samp, m_col, m_beat;

  always #5 clk = ~clk;

  apxoa_final_add #(.W(W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .sum_vec      (sum_vec),
    .carry_vec    (carry_vec),
    .err_vec      (err_vec),
    .comp_en      (comp_en),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .out_err      (out_err),
    .clr_stats    (clr_stats),
    .sample_cnt   (sample_cnt),
    .err_col_cnt  (err_col_cnt),
    .err_beat_cnt (err_beat_cnt)
  );

  function automatic int clampc(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // Advances one clock, updating the reference model from the handshakes seen before the edge.
  task automatic tick(output bit acc, output bit fired, output int got, output bit got_err,
                      output int exp, output bit exp_err, output bit underflow);
    #1;
    acc = 0; fired = 0; got = 0; got_err = 0; exp = -1; exp_err = 0; underflow = 0;
    if (rst_n) begin
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        fired = 1; got = int'(result); got_err = out_err;
        if (q_res.size() == 0) underflow = 1;
        else begin exp = q_res.pop_front(); exp_err = q_err.pop_front(); end
      end
      if (acc) begin
        q_res.push_back(int'(sum_vec) + 2 * int'(carry_vec) + (comp_en ? 2 * int'(err_vec) : 0));
        q_err.push_back(err_vec != 0);
      end
      if (clr_stats) begin
        m_samp = 0; m_col = 0; m_beat = 0;
      end else if (acc) begin
        m_samp = clampc(m_samp + 1);
        m_col  = clampc(m_col + $countones(err_vec));
        m_beat = clampc(m_beat + ((err_vec != 0) ? 1 : 0));
      end
    end else begin
      q_res.delete(); q_err.delete();
      m_samp = 0; m_col = 0; m_beat = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [W-1:0] s, input logic [W-1:0] c, input logic [W-1:0] e,
                          input logic ce);
    in_valid = 1; sum_vec = s; carry_vec = c; err_vec = e; comp_en = ce;
  endtask

  task automatic test_reset();
    bit a, f, ge, ee, u; int g, x;
    rst_n = 0; in_valid = 0; out_ready = 0; clr_stats = 0; comp_en = 0;
    sum_vec = '0; carry_vec = '0; err_vec = '0;
    tick(a, f, g, ge, x, ee, u);
    tick(a, f, g, ge, x, ee, u);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL reset_result: got %0h expected 0", result); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL reset_out_err: got %0b expected 0", out_err); end
    n_cmp++; if ({sample_cnt, err_col_cnt, err_beat_cnt} !== '0)
      begin n_bad++; $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", sample_cnt, err_col_cnt, err_beat_cnt); end
    rst_n = 1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    bit a, f, ge, ee, u; int g, x;
    out_ready = 1;
    // Plain carry-propagate, no error flags.
    set_beat(8'hFF, 8'hFF, 8'h00, 1'b0);
    tick(a, f, g, ge, x, ee, u);
    in_valid = 0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_latency_n1: got out_valid %0b expected 0", out_valid); end
    n_cmp++; if (sample_cnt !== 4'd1 || err_col_cnt !== 4'd0)
      begin n_bad++; $display("FAIL basic_cnt: got %0d/%0d expected 1/0", sample_cnt, err_col_cnt); end
    tick(a, f, g, ge, x, ee, u);
    n_cmp++; if (out_valid !== 1'b1 || result !== 11'h2FD || out_err !== 1'b0)
      begin n_bad++; $display("FAIL basic_result: got v=%0b r=%0h e=%0b expected v=1 r=2fd e=0", out_valid, result, out_err); end
    tick(a, f, g, ge, x, ee, u);
    // Full error flags with and without compensation; counters cleared in between.
    for (int k = 0; k < 2; k++) begin
      in_valid = 0; clr_stats = 1;
      tick(a, f, g, ge, x, ee, u);
      clr_stats = 0;
      set_beat(8'hFF, 8'hFF, 8'hFF, (k == 0));
      tick(a, f, g, ge, x, ee, u);
      in_valid = 0;
      n_cmp++; if (err_col_cnt !== 4'd8 || err_beat_cnt !== 4'd1 || sample_cnt !== 4'd1)
        begin n_bad++; $display("FAIL comp_cnt_%0d: got %0d/%0d/%0d expected 1/8/1", k, sample_cnt, err_col_cnt, err_beat_cnt); end
      tick(a, f, g, ge, x, ee, u);
      n_cmp++; if (result !== ((k == 0) ? 11'h4FB : 11'h2FD) || out_err !== 1'b1)
        begin n_bad++; $display("FAIL comp_result_%0d: got r=%0h e=%0b expected r=%0h e=1", k, result, out_err, (k == 0) ? 11'h4FB : 11'h2FD); end
      tick(a, f, g, ge, x, ee, u);
    end
    $display("test_basic done");
  endtask

  task automatic test_stream();
    bit a, f, ge, ee, u; int g, x; int fires; int acc_n; int snap;
    fires = 0; acc_n = 0;
    clr_stats = 0; out_ready = 1;
    for (int k = 0; k < 23; k++) begin
      if (k < 20) set_beat(W'($urandom), W'($urandom), W'($urandom), 1'($urandom));
      else in_valid = 0;
      tick(a, f, g, ge, x, ee, u);
      if (k < 20) begin
        n_cmp++; if (!a) begin n_bad++; $display("FAIL stream_accept_%0d: got in_ready 0 expected 1", k); end
      end
      if (f) begin
        fires++;
        n_cmp++; if (u || g != x || ge != ee)
          begin n_bad++; $display("FAIL stream_data_%0d: got %0h/%0b expected %0h/%0b", k, g, ge, x, ee); end
      end
      $display("stream cycle %0d acc=%0b out=%0b res=%0h", k, a, f, g);
    end
    n_cmp++; if (fires != 20) begin n_bad++; $display("FAIL stream_count: got %0d expected 20", fires); end
    // Backpressure: two beats fill the pipe, then in_ready must drop and result hold.
    out_ready = 0; snap = 0;
    for (int k = 0; k < 5; k++) begin
      set_beat(W'($urandom), W'($urandom), W'($urandom), 1'($urandom));
      tick(a, f, g, ge, x, ee, u);
      if (a) acc_n++;
      n_cmp++; if (a != (k < 2))
        begin n_bad++; $display("FAIL bp_in_ready_%0d: got %0b expected %0b", k, a, (k < 2)); end
      if (k == 1) snap = int'(result);
      if (k >= 2) begin
        n_cmp++; if (out_valid !== 1'b1 || int'(result) != snap)
          begin n_bad++; $display("FAIL bp_hold_%0d: got v=%0b r=%0h expected v=1 r=%0h", k, out_valid, result, snap); end
      end
    end
    in_valid = 0; out_ready = 1; fires = 0;
    for (int k = 0; k < 4; k++) begin
      tick(a, f, g, ge, x, ee, u);
      if (f) begin
        fires++;
        n_cmp++; if (u || g != x || ge != ee)
          begin n_bad++; $display("FAIL bp_data_%0d: got %0h/%0b expected %0h/%0b", k, g, ge, x, ee); end
      end
    end
    n_cmp++; if (fires != acc_n || acc_n != 2)
      begin n_bad++; $display("FAIL bp_count: got %0d out of %0d accepted expected 2", fires, acc_n); end
    $display("test_stream done");
  endtask

  task automatic test_saturation();
    bit a, f, ge, ee, u; int g, x;
    out_ready = 1; in_valid = 0; clr_stats = 1;
    tick(a, f, g, ge, x, ee, u);
    clr_stats = 0;
    for (int k = 0; k < 20; k++) begin
      set_beat(W'($urandom), W'($urandom), 8'h0F, 1'($urandom));
      tick(a, f, g, ge, x, ee, u);
      n_cmp++; if (int'(sample_cnt) != m_samp || int'(err_col_cnt) != m_col || int'(err_beat_cnt) != m_beat)
        begin n_bad++; $display("FAIL sat_cnt_%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", k, sample_cnt, err_col_cnt, err_beat_cnt, m_samp, m_col, m_beat); end
      if (f) begin
        n_cmp++; if (u || g != x) begin n_bad++; $display("FAIL sat_data_%0d: got %0h expected %0h", k, g, x); end
      end
    end
    n_cmp++; if (sample_cnt !== 4'd15 || err_col_cnt !== 4'd15 || err_beat_cnt !== 4'd15)
      begin n_bad++; $display("FAIL sat_final: got %0d/%0d/%0d expected 15/15/15", sample_cnt, err_col_cnt, err_beat_cnt); end
    set_beat(8'h01, 8'h02, 8'hFF, 1'b1);
    clr_stats = 1;
    tick(a, f, g, ge, x, ee, u);
    clr_stats = 0; in_valid = 0;
    n_cmp++; if (!a || {sample_cnt, err_col_cnt, err_beat_cnt} !== '0)
      begin n_bad++; $display("FAIL clr_wins: got acc=%0b %0d/%0d/%0d expected acc=1 0/0/0", a, sample_cnt, err_col_cnt, err_beat_cnt); end
    for (int k = 0; k < 4; k++) begin
      tick(a, f, g, ge, x, ee, u);
      if (f) begin
        n_cmp++; if (u || g != x) begin n_bad++; $display("FAIL clr_data_%0d: got %0h expected %0h", k, g, x); end
      end
    end
    $display("test_saturation done");
  endtask

  task automatic test_reset_mid();
    bit a, f, ge, ee, u; int g, x; int want;
    out_ready = 0;
    for (int k = 0; k < 2; k++) begin
      set_beat(W'($urandom), W'($urandom), W'($urandom), 1'b1);
      tick(a, f, g, ge, x, ee, u);
    end
    in_valid = 0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_full: got out_valid %0b expected 1", out_valid); end
    rst_n = 0;
    tick(a, f, g, ge, x, ee, u);
    rst_n = 1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || {sample_cnt, err_col_cnt, err_beat_cnt} !== '0)
      begin n_bad++; $display("FAIL mid_reset: got v=%0b rdy=%0b cnt=%0d/%0d/%0d expected v=0 rdy=1 cnt=0", out_valid, in_ready, sample_cnt, err_col_cnt, err_beat_cnt); end
    // Wait out the extra delay so the next edge is a clean cycle boundary.
    @(posedge clk); #1;
    out_ready = 1;
    set_beat(8'h12, 8'h34, 8'h01, 1'b1);
    want = 'h12 + 2 * 'h34 + 2;
    tick(a, f, g, ge, x, ee, u);
    in_valid = 0;
    n_cmp++; if (!a || out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_n1: got acc=%0b v=%0b expected acc=1 v=0", a, out_valid); end
    tick(a, f, g, ge, x, ee, u);
    n_cmp++; if (out_valid !== 1'b1 || int'(result) != want || out_err !== 1'b1)
      begin n_bad++; $display("FAIL mid_n2: got v=%0b r=%0h e=%0b expected v=1 r=%0h e=1", out_valid, result, out_err, want); end
    tick(a, f, g, ge, x, ee, u);
    n_cmp++; if (!f || u || g != x) begin n_bad++; $display("FAIL mid_drain: got fired=%0b r=%0h expected %0h", f, g, x); end
    $display("test_reset_mid done");
  endtask

  initial begin
    m_samp = 0; m_col = 0; m_beat = 0;
    test_reset();
    test_basic();
    test_stream();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
